// File: rtl/windowed_register_file.sv
// windowed_register_file
// SPARC-style windowed integer register file: 8 globals plus NWINDOWS windows
// of 16 physical registers (8 outs + 8 locals each). The current window pointer
// moves on SAVE (down) and RESTORE (up). All 32 architectural registers of the
// current window are presented combinationally on R0..R31.
// Optional feature macro: WINDOW_TRAP_EN. When it is defined, SAVE/RESTORE into a
// window marked in WIM is refused and pulses Window_Trap. When it is undefined,
// WIM is ignored and the trap outputs stay 0.
module windowed_register_file #(
    parameter int NWINDOWS = 4,
    parameter int CWP_W    = 5
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                Write_Enable,
    input  logic [4:0]          Write_Select,
    input  logic [31:0]         Write_Data,
    input  logic                Save,
    input  logic                Restore,
    input  logic [NWINDOWS-1:0] WIM,
    output logic [CWP_W-1:0]    CWP,
    output logic                Window_Trap,
    output logic                Trap_Type,
    output logic [31:0]         R0,  output logic [31:0] R1,  output logic [31:0] R2,  output logic [31:0] R3,
    output logic [31:0]         R4,  output logic [31:0] R5,  output logic [31:0] R6,  output logic [31:0] R7,
    output logic [31:0]         R8,  output logic [31:0] R9,  output logic [31:0] R10, output logic [31:0] R11,
    output logic [31:0]         R12, output logic [31:0] R13, output logic [31:0] R14, output logic [31:0] R15,
    output logic [31:0]         R16, output logic [31:0] R17, output logic [31:0] R18, output logic [31:0] R19,
    output logic [31:0]         R20, output logic [31:0] R21, output logic [31:0] R22, output logic [31:0] R23,
    output logic [31:0]         R24, output logic [31:0] R25, output logic [31:0] R26, output logic [31:0] R27,
    output logic [31:0]         R28, output logic [31:0] R29, output logic [31:0] R30, output logic [31:0] R31
);

    // Physical layout: G[0..7] at 0..7, then per window w: O[w] at 8+16w, L[w] at 16+16w.
    localparam int NPHYS = 8 + 16 * NWINDOWS;
    localparam int PW    = $clog2(NPHYS);

`ifdef WINDOW_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic [31:0]      regs_reg [NPHYS];
    logic [CWP_W-1:0] cwp_reg, cwp_next;
    logic             trap_reg, trap_next;
    logic             type_reg, type_next;
    logic [CWP_W-1:0] cwp_up;     // (CWP + 1) mod NWINDOWS: RESTORE target and owner of the ins
    logic [CWP_W-1:0] cwp_down;   // (CWP - 1) mod NWINDOWS: SAVE target
    logic             down_invalid, up_invalid;
    logic [PW-1:0]    write_addr;
    logic [31:0]      view [32];

    // Map an architectural register number to its physical slot for the given window.
    function automatic logic [PW-1:0] phys_addr(input logic [4:0] arch,
                                                input logic [CWP_W-1:0] cur,
                                                input logic [CWP_W-1:0] nxt);
        logic [PW-1:0] base_cur;
        logic [PW-1:0] base_nxt;
        logic [PW-1:0] offs;
        base_cur = PW'(8) + (PW'(cur) << 4);
        base_nxt = PW'(8) + (PW'(nxt) << 4);
        offs     = PW'(arch[2:0]);
        case (arch[4:3])
            2'd0:    return offs;                    // globals
            2'd1:    return base_cur + offs;         // outs of this window
            2'd2:    return base_cur + PW'(8) + offs; // locals of this window
            default: return base_nxt + offs;         // ins = outs of the caller window
        endcase
    endfunction

    assign cwp_up     = (cwp_reg == CWP_W'(NWINDOWS - 1)) ? '0 : cwp_reg + CWP_W'(1);
    assign cwp_down   = (cwp_reg == '0) ? CWP_W'(NWINDOWS - 1) : cwp_reg - CWP_W'(1);
    assign write_addr = phys_addr(Write_Select, cwp_reg, cwp_up);

    // Window pointer and trap decision for the next edge.
    always_comb begin
        cwp_next     = cwp_reg;
        trap_next    = 1'b0;
        type_next    = 1'b0;
        down_invalid = 1'b0;
        up_invalid   = 1'b0;
        for (int w = 0; w < NWINDOWS; w++) begin
            if (cwp_down == CWP_W'(w)) down_invalid = WIM[w];
            if (cwp_up   == CWP_W'(w)) up_invalid   = WIM[w];
        end
        if (Save && !Restore) begin
            if (TRAP_EN && down_invalid) begin
                trap_next = 1'b1;
                type_next = 1'b0;
            end else begin
                cwp_next = cwp_down;
            end
        end else if (Restore && !Save) begin
            if (TRAP_EN && up_invalid) begin
                trap_next = 1'b1;
                type_next = 1'b1;
            end else begin
                cwp_next = cwp_up;
            end
        end
    end

    // Control state: CWP and the one-cycle trap pulse.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            cwp_reg  <= '0;
            trap_reg <= 1'b0;
            type_reg <= 1'b0;
        end else begin
            cwp_reg  <= cwp_next;
            trap_reg <= trap_next;
            type_reg <= type_next;
        end
    end

    // Register storage; the write resolves against the window held before the edge.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < NPHYS; i++) regs_reg[i] <= '0;
        end else if (Write_Enable && (Write_Select != 5'd0)) begin
            regs_reg[write_addr] <= Write_Data;
        end
    end

    // Combinational current-window view; r0 is hard-wired to zero.
    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_view
            if (gi == 0) begin : g_zero
                assign view[gi] = '0;
            end else begin : g_reg
                assign view[gi] = regs_reg[phys_addr(5'(gi), cwp_reg, cwp_up)];
            end
        end
    endgenerate

    assign CWP         = cwp_reg;
    assign Window_Trap = trap_reg;
    assign Trap_Type   = type_reg;

    assign R0  = view[0];  assign R1  = view[1];  assign R2  = view[2];  assign R3  = view[3];
    assign R4  = view[4];  assign R5  = view[5];  assign R6  = view[6];  assign R7  = view[7];
    assign R8  = view[8];  assign R9  = view[9];  assign R10 = view[10]; assign R11 = view[11];
    assign R12 = view[12]; assign R13 = view[13]; assign R14 = view[14]; assign R15 = view[15];
    assign R16 = view[16]; assign R17 = view[17]; assign R18 = view[18]; assign R19 = view[19];
    assign R20 = view[20]; assign R21 = view[21]; assign R22 = view[22]; assign R23 = view[23];
    assign R24 = view[24]; assign R25 = view[25]; assign R26 = view[26]; assign R27 = view[27];
    assign R28 = view[28]; assign R29 = view[29]; assign R30 = view[30]; assign R31 = view[31];

endmodule

// File: doc/windowed_register_file.md
# windowed_register_file

SPARC windowed integer register file for the data path. Holds 8 globals plus NWINDOWS windows of 16 physical registers, tracks the current window pointer (CWP) across SAVE/RESTORE, and presents the 32 architecturally visible registers of the current window as R0..R31. Those outputs feed the Register A/B operand multiplexers directly. Write-back drives the write port.

## Interface
- NWINDOWS, 4: number of register windows; 2..32. Physical storage is 8 + 16·NWINDOWS words of 32 bits.
- CWP_W, 5: width of CWP; must satisfy 2^CWP_W ≥ NWINDOWS.

- Clk  in  1: single clock. All state changes on the rising edge.
- Reset  in  1: synchronous, active-high.
- Write_Enable  in  1: write Write_Data into the register selected by Write_Select.
- Write_Select  in  5: architectural register number, 0..31, in the current window.
- Write_Data  in  32: write-back data.
- Save  in  1: SAVE request. Decrements CWP.
- Restore  in  1: RESTORE request. Increments CWP.
- WIM  in  NWINDOWS: window invalid mask, one bit per window.
- CWP  out  CWP_W: current window pointer (registered).
- Window_Trap  out  1: one-cycle pulse when a SAVE or RESTORE is refused.
- Trap_Type  out  1: 0 = overflow (SAVE), 1 = underflow (RESTORE). Valid while Window_Trap = 1.
- R31..R0  out  32 each: current-window view. Combinational from the storage and CWP.

## Operation
- Architectural-to-physical mapping for window c:
  - r0–r7 → G[0..7]. G[0] reads as 0; writes to it are discarded.
  - r8–r15 (outs) → O[c][0..7].
  - r16–r23 (locals) → L[c][0..7].
  - r24–r31 (ins) → O[(c+1) mod NWINDOWS][0..7].
- Write: when Write_Enable = 1, the selected physical register takes Write_Data at the edge. The mapping uses the CWP value held before that edge.
- SAVE (Save = 1, Restore = 0):
  - next = (CWP − 1) mod NWINDOWS. At CWP = 0, next = NWINDOWS−1.
  - If trapping is enabled and WIM[next] = 1: CWP holds, Window_Trap = 1, Trap_Type = 0.
  - Otherwise CWP takes next.
- RESTORE (Restore = 1, Save = 0):
  - next = (CWP + 1) mod NWINDOWS. At CWP = NWINDOWS−1, next = 0.
  - Trap check as for SAVE, with Trap_Type = 1.
- Save and Restore both 1: no CWP change, no trap. The write still proceeds.
- Write together with SAVE/RESTORE: the write lands in the old window; CWP changes on the same edge. A trapped SAVE/RESTORE does not suppress the write.
- Reset: all physical registers = 0, CWP = 0, Window_Trap = 0, Trap_Type = 0. Every R output reads 0 after reset. Reset overrides write, Save and Restore in the same cycle, including mid-sequence.

## Timing
- Write latency: a write issued in cycle n is visible on R outputs in cycle n+1. There is no same-cycle write-through bypass; forwarding belongs to the pipeline.
- SAVE/RESTORE: CWP and the R-output mapping change in cycle n+1.
- Window_Trap/Trap_Type: registered; high for exactly cycle n+1, then 0 unless re-triggered.
- Back-to-back SAVE/RESTORE on consecutive cycles are each honoured.
- R outputs: purely combinational from state. No input-to-output combinational path except through storage.

## Configuration
- WINDOW_TRAP_EN defined:
  - WIM is checked as above; refused SAVE/RESTORE leave CWP unchanged and pulse Window_Trap.
- WINDOW_TRAP_EN undefined:
  - WIM is ignored.
  - CWP always moves modulo NWINDOWS; on wrap, the oldest window is silently overwritten.
  - Window_Trap and Trap_Type are tied to 0.

## Test plan
- Reset, then write r5 = 0x1234_5678 and r0 = 0xFFFF_FFFF → next cycle R5 = 0x1234_5678, R0 = 0, CWP = 0.
- At CWP = 0, write r9 = 0xAAAA_0001, then SAVE with WIM = 0 → CWP = 3 (NWINDOWS = 4) and R25 = 0xAAAA_0001. Then RESTORE → CWP = 0 and R9 = 0xAAAA_0001.
- At CWP = 0, write r17 = 0xBEEF, then SAVE → R17 = 0 in window 3. Write r17 = 0x55 and RESTORE → R17 = 0xBEEF.
- WINDOW_TRAP_EN, CWP = 0, WIM = 4'b1000, SAVE → CWP stays 0, Window_Trap = 1 for one cycle, Trap_Type = 0. Repeat with CWP = 3, WIM = 4'b0001, RESTORE → Trap_Type = 1, CWP stays 3.
- Write r10 = 0x77 with Save = Restore = 1 → CWP unchanged, no trap, R10 = 0x77. Then assert Reset with Save = 1 → CWP = 0 and all R outputs = 0.
- Without WINDOW_TRAP_EN, WIM = 4'b1111, four SAVEs from CWP = 0 → CWP sequence 3, 2, 1, 0 and Window_Trap stays 0.
